receiver: RTL

RECEIVER -- requirements
Module: receiver

---
 rtl/receiver.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/receiver.sv
// Serial frame receiver: start, 4-bit size, up to 15 bytes, CRC byte and stop bit, all MSB first.
// Define RECEIVER_CRC_CHECK_EN to build the CRC-8 checker; otherwise crcerr is tied to 0.
`timescale 1ns/1ps
module receiver (
    input  logic         clk,
    input  logic         reset,
    input  logic         RX,
    input  logic [7:0]   baudrate,
    output logic         RXI,
    output logic [3:0]   framesize,
    output logic [127:0] framebits,
    output logic         valid,
    output logic         crcerr,
    output logic         ferr
);

    typedef enum logic [2:0] {IDLE, START, SIZE, DATA, CRC, STOP} state_t;

    state_t         r_state, w_state;
    logic           r_rxQ;
    logic [7:0]     r_period, w_period;
    logic [7:0]     r_clkCnt, w_clkCnt;
    logic [2:0]     r_bitIdx, w_bitIdx;
    logic [3:0]     r_byteIdx, w_byteIdx;
    logic [3:0]     r_framesize, w_framesize;
    logic [127:0]   r_framebits, w_framebits;
    logic           r_valid, w_valid;
    logic           r_ferr, w_ferr;
    logic           w_rise, w_sample, w_endBit;
    logic [6:0]     w_bitPos;

    // Edges are detected on the raw line but bits are taken from r_rxQ, so counter
    // value j lines up with the j-th clock of the transmitted bit (works down to P=2).
    assign w_rise   = RX & ~r_rxQ;
    assign w_sample = (r_clkCnt == (r_period >> 1));
    assign w_endBit = (r_clkCnt == (r_period - 8'd1));
    assign w_bitPos = {r_byteIdx, ~r_bitIdx};

    always_ff @(posedge clk) begin
        r_rxQ <= RX;
    end

    always_comb begin
        w_state     = r_state;
        w_period    = r_period;
        w_clkCnt    = r_clkCnt;
        w_bitIdx    = r_bitIdx;
        w_byteIdx   = r_byteIdx;
        w_framesize = r_framesize;
        w_framebits = r_framebits;
        w_valid     = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state     = START;
                    w_clkCnt    = 8'd0;
                    w_bitIdx    = 3'd0;
                    w_byteIdx   = 4'd0;
                    w_period    = (baudrate < 8'd2) ? 8'd2 : baudrate;
                    w_framesize = 4'd0;
                    w_framebits = '0;
                end
            end
            START: begin
                w_clkCnt = w_endBit ? 8'd0 : r_clkCnt + 8'd1;
                if (w_sample && !r_rxQ) begin
                    w_state  = IDLE;
                    w_clkCnt = 8'd0;
                end else if (w_endBit) begin
                    w_state = SIZE;
                end
            end
            SIZE: begin
                w_clkCnt = w_endBit ? 8'd0 : r_clkCnt + 8'd1;
                if (w_sample)
                    w_framesize = {r_framesize[2:0], r_rxQ};
                if (w_endBit) begin
                    if (r_bitIdx == 3'd3) begin
                        w_bitIdx = 3'd0;
                        w_state  = (w_framesize == 4'd0) ? CRC : DATA;
                    end else begin
                        w_bitIdx = r_bitIdx + 3'd1;
                    end
                end
            end
            DATA: begin
                w_clkCnt = w_endBit ? 8'd0 : r_clkCnt + 8'd1;
                if (w_sample)
                    w_framebits[w_bitPos] = r_rxQ;
                if (w_endBit) begin
                    w_bitIdx = r_bitIdx + 3'd1;
                    if (r_bitIdx == 3'd7) begin
                        if (r_byteIdx == r_framesize - 4'd1) begin
                            w_byteIdx = 4'd0;
                            w_state   = CRC;
                        end else begin
                            w_byteIdx = r_byteIdx + 4'd1;
                        end
                    end
                end
            end
            CRC: begin
                w_clkCnt = w_endBit ? 8'd0 : r_clkCnt + 8'd1;
                if (w_endBit) begin
                    w_bitIdx = r_bitIdx + 3'd1;
                    if (r_bitIdx == 3'd7)
                        w_state = STOP;
                end
            end
            STOP: begin
                w_clkCnt = r_clkCnt + 8'd1;
                if (w_sample) begin
                    w_state  = IDLE;
                    w_clkCnt = 8'd0;
                    w_valid  = ~r_rxQ;
                    w_ferr   = r_rxQ;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_period    <= 8'd0;
            r_clkCnt    <= 8'd0;
            r_bitIdx    <= 3'd0;
            r_byteIdx   <= 4'd0;
            r_framesize <= 4'd0;
            r_framebits <= '0;
            r_valid     <= 1'b0;
            r_ferr      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_period    <= w_period;
            r_clkCnt    <= w_clkCnt;
            r_bitIdx    <= w_bitIdx;
            r_byteIdx   <= w_byteIdx;
            r_framesize <= w_framesize;
            r_framebits <= w_framebits;
            r_valid     <= w_valid;
            r_ferr      <= w_ferr;
        end
    end

    assign RXI       = (r_state == IDLE);
    assign framesize = r_framesize;
    assign framebits = r_framebits;
    assign valid     = r_valid;
    assign ferr      = r_ferr;

`ifdef RECEIVER_CRC_CHECK_EN
    logic [7:0] r_crc, r_rxcrc;
    logic       r_crcerr;
    logic       w_crcShift, w_rxcrcShift, w_frameEnd;

    function automatic logic [7:0] crcStep(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    assign w_crcShift   = w_sample && (r_state == SIZE || r_state == DATA);
    assign w_rxcrcShift = w_sample && (r_state == CRC);
    assign w_frameEnd   = w_sample && (r_state == STOP);

    // The check result is latched at the stop sample so it lands with valid/ferr.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc    <= 8'd0;
            r_rxcrc  <= 8'd0;
            r_crcerr <= 1'b0;
        end else begin
            if (r_state == IDLE && w_rise)
                r_crc <= 8'd0;
            else if (w_crcShift)
                r_crc <= crcStep(r_crc, r_rxQ);
            if (w_rxcrcShift)
                r_rxcrc <= {r_rxcrc[6:0], r_rxQ};
            if (w_frameEnd)
                r_crcerr <= (r_crc != r_rxcrc);
        end
    end

    assign crcerr = r_crcerr;
`else
    assign crcerr = 1'b0;
`endif

endmodule
